// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: MMIO register map, STATUS layout
// and the default MMIO window base.
package mem_responder_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hF000_0000;

   // Register select taken from address[3:2] inside the MMIO window
   typedef enum logic [1:0] {
      REG_TX     = 2'd0,
      REG_STATUS = 2'd1,
      REG_CYCLES = 2'd2,
      REG_RSVD   = 2'd3
   } mmio_reg_e;

   localparam int STATUS_FULL_BIT  = 0;
   localparam int STATUS_EMPTY_BIT = 1;
   localparam int STATUS_OVF_BIT   = 2;

   typedef enum logic {
      SEL_REG = 1'b0,
      SEL_RAM = 1'b1
   } rd_sel_e;

   function automatic logic [31:0] status_word(input logic full,
                                               input logic empty,
                                               input logic ovf);
      logic [31:0] w;
      w                   = '0;
      w[STATUS_FULL_BIT]  = full;
      w[STATUS_EMPTY_BIT] = empty;
      w[STATUS_OVF_BIT]   = ovf;
      return w;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus plus console byte stream of the memory responder.
interface mem_responder_if;

   logic [31:0] address;
   logic        data_rw;
   logic [31:0] data_out;
   logic [31:0] data_in;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output address, data_rw, data_out, tx_ready,
      input  data_in, tx_data, tx_valid
   );

   modport slave (
      input  address, data_rw, data_out, tx_ready,
      output data_in, tx_data, tx_valid
   );

endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO for the console TX path. A push into a full FIFO is accepted only
// when a pop happens on the same edge; the caller tracks rejected pushes.
module tx_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [7:0]             head
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head is forced to zero when empty so reset clears the visible byte at once
   assign head = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_responder.sv
// Single-cycle memory responder: word RAM, console TX FIFO and a small MMIO
// window (TX, STATUS, CYCLES). Reads return one cycle after the address edge.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);

   localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic rst_meta_n;
   logic rst_n;

   // Asserts immediately, releases two edges after reset goes high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta_n <= 1'b0;
         rst_n      <= 1'b0;
      end else begin
         rst_meta_n <= 1'b1;
         rst_n      <= rst_meta_n;
      end
   end

   // Plain flop copy of reset state, used to gate the unreset RAM write port
   logic live;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live <= 1'b0;
      else        live <= 1'b1;
   end

   logic            in_ram;
   logic            in_mmio;
   logic            mmio_hit;
   logic            wr_en;
   logic            rd_en;
   mmio_reg_e       reg_sel;
   logic [RAM_AW-1:0] ram_idx;
   logic            unused_addr_bits;

   assign in_ram           = (bus.address[31:RAM_AW+2] == '0);
   assign in_mmio          = (bus.address[31:4] == MMIO_BASE[31:4]);
   assign mmio_hit         = in_mmio && !in_ram;
   assign reg_sel          = mmio_reg_e'(bus.address[3:2]);
   assign ram_idx          = bus.address[RAM_AW+1:2];
   assign wr_en            = bus.data_rw && live;
   assign rd_en            = !bus.data_rw && live;
   assign unused_addr_bits = ^bus.address[1:0];

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] ram_q;

   // Single-port, read port only updates on read cycles so data_in holds on writes
   always_ff @(posedge clk) begin
      if (wr_en && in_ram)      ram[ram_idx] <= bus.data_out;
      else if (rd_en && in_ram) ram_q        <= ram[ram_idx];
   end

   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   assign push         = wr_en && mmio_hit && (reg_sel == REG_TX);
   assign pop          = bus.tx_valid && bus.tx_ready;
   assign bus.tx_valid = !fifo_empty;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (bus.data_out[7:0]),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (bus.tx_data)
   );

   logic        overflow;
   logic        ovf_set;
   logic        ovf_clr;
   logic [31:0] cycle_cnt;
   logic [31:0] mmio_rdata;
   logic [31:0] reg_q;
   rd_sel_e     sel_q;

   assign ovf_set = push && fifo_full && !pop;
   assign ovf_clr = wr_en && mmio_hit && (reg_sel == REG_STATUS)
                    && bus.data_out[STATUS_OVF_BIT];

   always_comb begin
      mmio_rdata = '0;
      case (reg_sel)
         REG_TX:     mmio_rdata = 32'(fifo_count);
         REG_STATUS: mmio_rdata = status_word(fifo_full, fifo_empty, overflow);
         REG_CYCLES: mmio_rdata = cycle_cnt;
         default:    mmio_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         cycle_cnt <= '0;
         sel_q     <= SEL_REG;
         reg_q     <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         // A new overflow wins over a clear on the same edge
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (rd_en) begin
            if (in_ram) begin
               sel_q <= SEL_RAM;
            end else begin
               sel_q <= SEL_REG;
               reg_q <= mmio_hit ? mmio_rdata : '0;
            end
         end
      end
   end

   assign bus.data_in = (sel_q == SEL_RAM) ? ram_q : reg_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expected read data and
// console bytes, a monitor compares them as the DUT presents them.
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam logic [31:0] TX_A  = 32'hF000_0000;
   localparam logic [31:0] ST_A  = 32'hF000_0004;
   localparam logic [31:0] CY_A  = 32'hF000_0008;
   localparam logic [31:0] RS_A  = 32'hF000_000C;
   localparam logic [31:0] BAD_A = 32'h8000_0000;

   typedef struct {
      logic [31:0] val;
      logic        chk;
      string       name;
   } rd_exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   rd_exp_t    rdq[$];
   logic [7:0] txq[$];

   mem_responder_if bus();

   mem_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n,
                     input logic c = 1'b1);
      @(negedge clk);
      bus.address  = a;
      bus.data_rw  = 1'b0;
      bus.data_out = '0;
      chk_en       = 1'b1;
      rdq.push_back('{val: v, chk: c, name: n});
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address  = a;
      bus.data_rw  = 1'b1;
      bus.data_out = d;
      chk_en       = 1'b0;
   endtask

   // Write cycle that also checks data_in keeps its previous value
   task automatic wr_hold(input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] prev, input string n);
      @(negedge clk);
      bus.address  = a;
      bus.data_rw  = 1'b1;
      bus.data_out = d;
      chk_en       = 1'b1;
      rdq.push_back('{val: prev, chk: 1'b1, name: n});
   endtask

   task automatic idle();
      @(negedge clk);
      bus.address  = BAD_A;
      bus.data_rw  = 1'b0;
      bus.data_out = '0;
      chk_en       = 1'b0;
   endtask

   initial begin : monitor
      logic    rd_now;
      logic    tx_now;
      rd_exp_t e;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         #1;
         rd_now = chk_en;
         tx_now = bus.tx_valid && bus.tx_ready;
         if (tx_now) begin
            if (txq.size() == 0) begin
               check("tx_unexpected_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
            end else begin
               b = txq.pop_front();
               check("tx_byte", 32'(bus.tx_data), 32'(b));
            end
         end
         @(posedge clk);
         #1;
         if (rd_now) begin
            if (rdq.size() == 0) begin
               check("rd_unexpected", bus.data_in, 32'hFFFF_FFFF);
            end else begin
               e = rdq.pop_front();
               if (e.chk) check(e.name, bus.data_in, e.val);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      logic [31:0] c0;
      logic [31:0] c1;
      int          n;
      bus.address  = BAD_A;
      bus.data_rw  = 1'b0;
      bus.data_out = '0;
      bus.tx_ready = 1'b0;
      #3;
      check("rst_data_in",  bus.data_in, 32'h0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("rst_tx_data",  32'(bus.tx_data), 32'h0);
      #20 reset = 1'b1;
      repeat (4) idle();

      // RAM access, alignment, write-hold, boundaries and unmapped space
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
      rd(32'h13, 32'hDEAD_BEEF, "ram_rd_low_bits");
      wr_hold(32'h20, 32'h0BAD_F00D, 32'hDEAD_BEEF, "wr_holds_data_in");
      rd(32'h20, 32'h0BAD_F00D, "ram_rd2");
      wr(32'h0, 32'h1111_1111);
      wr(32'hFFC, 32'hCAFE_0001);
      wr(32'h1000, 32'h3333_3333);
      wr(BAD_A, 32'h2222_2222);
      wr(RS_A, 32'h0000_0004);
      wr(CY_A, 32'h0000_0000);
      rd(BAD_A, 32'h0, "unmapped_rd");
      rd(32'h1000, 32'h0, "ram_end_plus1_rd");
      rd(32'hFFC, 32'hCAFE_0001, "ram_last_word");
      rd(32'h0, 32'h1111_1111, "ram_no_alias");
      rd(ST_A, 32'h2, "status_idle");
      rd(TX_A, 32'h0, "count_idle");
      rd(RS_A, 32'h0, "rsvd_rd");
      rd(32'hF000_0010, 32'h0, "past_window_rd");

      // Push into empty FIFO: no bypass, byte held while not ready
      wr(TX_A, 32'h0000_0133);
      #1 check("no_bypass", 32'(bus.tx_valid), 32'h0);
      @(posedge clk);
      #1 check("valid_next_cycle", 32'(bus.tx_valid), 32'h1);
      idle();
      idle();
      #1 check("tx_data_stable", 32'(bus.tx_data), 32'h33);
      txq.push_back(8'h33);
      idle();
      bus.tx_ready = 1'b1;
      idle();
      bus.tx_ready = 1'b0;
      rd(ST_A, 32'h2, "status_after_single");

      // Nine pushes with sink stalled: eighth fills, ninth overflows
      for (int i = 0; i < 9; i++) wr(TX_A, 32'h41 + 32'(i));
      rd(ST_A, 32'h5, "status_full_ovf");
      rd(TX_A, 32'h8, "count_full");
      for (int i = 0; i < 8; i++) txq.push_back(8'(8'h41 + i));
      idle();
      bus.tx_ready = 1'b1;
      repeat (9) idle();
      rd(ST_A, 32'h6, "status_empty_ovf");
      rd(TX_A, 32'h0, "count_drained");
      bus.tx_ready = 1'b0;
      wr(ST_A, 32'h0000_0004);
      rd(ST_A, 32'h2, "ovf_cleared");

      // Full FIFO: push with simultaneous pop is accepted without overflow
      for (int i = 0; i < 9; i++) txq.push_back(8'(8'h50 + i));
      txq.push_back(8'h60);
      for (int i = 0; i < 8; i++) wr(TX_A, 32'h50 + 32'(i));
      rd(ST_A, 32'h1, "status_full");
      wr(TX_A, 32'h58);
      bus.tx_ready = 1'b1;
      idle();
      bus.tx_ready = 1'b0;
      rd(ST_A, 32'h1, "push_pop_full_no_ovf");
      rd(TX_A, 32'h8, "count_stays_full");
      idle();
      bus.tx_ready = 1'b1;
      wr(TX_A, 32'h60);
      rd(TX_A, 32'h7, "count_push_pop_mid");
      repeat (8) idle();
      bus.tx_ready = 1'b0;
      rd(ST_A, 32'h2, "status_after_wrap");

      // Cycle counter delta and wrap
      rd(CY_A, 32'h0, "cycles_a", 1'b0);
      @(posedge clk);
      #2 c0 = bus.data_in;
      repeat (9) idle();
      rd(CY_A, 32'h0, "cycles_b", 1'b0);
      @(posedge clk);
      #2 c1 = bus.data_in;
      check("cycles_delta", c1 - c0, 32'd10);
      idle();
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      #1 release dut.cycle_cnt;
      rd(CY_A, 32'hFFFF_FFFF, "cycles_max");
      rd(CY_A, 32'h0000_0000, "cycles_wrap");

      // Reset mid-stream with FIFO full, overflow set and a write in flight
      wr(32'h40, 32'hA5A5_A5A5);
      for (int i = 0; i < 9; i++) wr(TX_A, 32'h70 + 32'(i));
      rd(32'h10, 32'hDEAD_BEEF, "pre_reset_rd");
      wr(32'h40, 32'h5A5A_5A5A);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_data_in",  bus.data_in, 32'h0);
      check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("mid_rst_tx_data",  32'(bus.tx_data), 32'h0);
      repeat (2) @(negedge clk);
      idle();
      reset = 1'b1;
      repeat (4) idle();
      rd(ST_A, 32'h2, "post_rst_status");
      rd(TX_A, 32'h0, "post_rst_count");
      rd(32'h40, 32'hA5A5_A5A5, "inflight_write_dropped");
      rd(32'h10, 32'hDEAD_BEEF, "ram_survives_reset");

      n = 0;
      while ((rdq.size() != 0 || txq.size() != 0) && n < 50) begin
         idle();
         n++;
      end
      check("rd_queue_drained", 32'(rdq.size()), 32'h0);
      check("tx_queue_drained", 32'(txq.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
